// File: rtl/multi_mode_register_if.sv
// Control, data and result bundle for multi_mode_register.
// There is no valid/ready pair: every input is sampled on each rising clk
// while en=1. q and changed are registered; so is combinational from q and op.
interface multi_mode_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] t;
  logic             si;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             changed;

  modport master (
    output en, clr, op, d, j, k, t, si,
    input  q, so, changed
  );

  modport slave (
    input  en, clr, op, d, j, k, t, si,
    output q, so, changed
  );
endinterface

// File: rtl/multi_mode_register.sv
// WIDTH-bit register bank combining D, JK and T flip-flop behaviour with
// shift/rotate, synchronous clear, clock enable and a registered change flag.
module multi_mode_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  multi_mode_register_if.slave bus
);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_JK     = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_SHL    = 3'b100;
  localparam logic [2:0] OP_SHR    = 3'b101;
  localparam logic [2:0] OP_ROL    = 3'b110;
  localparam logic [2:0] OP_ROR    = 3'b111;

  logic [WIDTH-1:0] q_r;
  logic             changed_r;
  logic [WIDTH-1:0] next_q;
  logic             so_c;

  // Next value of q for an enabled edge; clr overrides the op.
  always_comb begin
    next_q = q_r;
    if (bus.clr) begin
      next_q = RESET_VAL;
    end else begin
      case (bus.op)
        OP_HOLD:   next_q = q_r;
        OP_LOAD:   next_q = bus.d;
        // JK per bit: set where j=1 and q=0, keep where k=0 and q=1.
        OP_JK:     next_q = (bus.j & ~q_r) | (~bus.k & q_r);
        OP_TOGGLE: next_q = q_r ^ bus.t;
        OP_SHL:    next_q = {q_r[WIDTH-2:0], bus.si};
        OP_SHR:    next_q = {bus.si, q_r[WIDTH-1:1]};
        OP_ROL:    next_q = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        OP_ROR:    next_q = {q_r[0], q_r[WIDTH-1:1]};
        default:   next_q = q_r;
      endcase
    end
  end

  // Serial out shows the bit the current op would shift out, independent of en.
  always_comb begin
    so_c = 1'b0;
    case (bus.op)
      OP_SHL, OP_ROL: so_c = q_r[WIDTH-1];
      OP_SHR, OP_ROR: so_c = q_r[0];
      default:        so_c = 1'b0;
    endcase
  end

  // Register update: async reset, then enable gates both q and changed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= RESET_VAL;
      changed_r <= 1'b0;
    end else if (bus.en) begin
      q_r       <= next_q;
      changed_r <= (next_q != q_r);
    end
  end

  assign bus.q       = q_r;
  assign bus.so      = so_c;
  assign bus.changed = changed_r;

endmodule

// File: tb/tb_multi_mode_register.sv
// Randomised and directed checks of multi_mode_register against a
// behavioural model; expectations are queued and checked by a monitor.
module tb_multi_mode_register;

  localparam int           W     = 8;
  localparam logic [W-1:0] RVAL  = 8'hA5;

  logic clk;
  logic rst;

  multi_mode_register_if #(.WIDTH(W)) bus ();

  multi_mode_register #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] m_q;
  logic         m_changed;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of one enabled edge
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic clr,
      input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] j,
      input logic [W-1:0] k, input logic [W-1:0] t, input logic si);
    logic [W-1:0] r;
    if (clr) return RVAL;
    case (op)
      3'd0: r = cur;
      3'd1: r = d;
      3'd2: begin
        r = cur;
        for (int i = 0; i < W; i++) begin
          if (j[i] && k[i])       r[i] = ~cur[i];
          else if (j[i])          r[i] = 1'b1;
          else if (k[i])          r[i] = 1'b0;
        end
      end
      3'd3: r = cur ^ t;
      3'd4: r = (cur << 1) | W'(si);
      3'd5: r = (cur >> 1) | (W'(si) << (W - 1));
      3'd6: r = (cur << 1) | (cur >> (W - 1));
      default: r = (cur >> 1) | (cur << (W - 1));
    endcase
    return r;
  endfunction

  function automatic logic model_so(input logic [W-1:0] cur, input logic [2:0] op);
    if (op == 3'd4 || op == 3'd6) return cur[W-1];
    if (op == 3'd5 || op == 3'd7) return cur[0];
    return 1'b0;
  endfunction

  // Driver: apply one cycle of inputs, check so, queue expected result
  task automatic drive(input logic en, input logic clr, input logic [2:0] op,
      input logic [W-1:0] d, input logic [W-1:0] j, input logic [W-1:0] k,
      input logic [W-1:0] t, input logic si);
    logic [W-1:0] nq;
    @(negedge clk);
    bus.en = en; bus.clr = clr; bus.op = op;
    bus.d = d; bus.j = j; bus.k = k; bus.t = t; bus.si = si;
    #1;
    check("so", {8'h00, bus.so}, {8'h00, model_so(m_q, op)});
    if (en) begin
      nq        = model_next(m_q, clr, op, d, j, k, t, si);
      m_changed = (nq != m_q);
      m_q       = nq;
    end
    exp_q.push_back({m_changed, m_q});
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.en = 1'b0; bus.clr = 1'b0; bus.op = 3'd0;
  endtask

  task automatic load(input logic [W-1:0] v);
    drive(1'b1, 1'b0, 3'd1, v, '0, '0, '0, 1'b0);
  endtask

  task automatic op1(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] j,
      input logic [W-1:0] k, input logic [W-1:0] t, input logic si);
    drive(1'b1, 1'b0, op, d, j, k, t, si);
  endtask

  // Reset asserted mid-cycle; q and changed must change before any clk edge
  task automatic mid_reset();
    go_idle();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    m_q = RVAL; m_changed = 1'b0;
    check("reset_async", {dut.bus.changed, dut.bus.q}, {1'b0, RVAL});
    @(posedge clk);
    #1;
    check("reset_hold", {bus.changed, bus.q}, {1'b0, RVAL});
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q_changed", {bus.changed, bus.q}, e);
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.op = 3'd0;
    bus.d = '0; bus.j = '0; bus.k = '0; bus.t = '0; bus.si = 1'b0;
    m_q = RVAL; m_changed = 1'b0;
    #2;
    check("reset_init", {bus.changed, bus.q}, {1'b0, RVAL});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // LOAD then JK
    load(8'h0F);
    op1(3'd2, '0, 8'hF0, 8'h3C, '0, 1'b0);
    // Shift with serial out
    load(8'h81);
    op1(3'd4, '0, '0, '0, '0, 1'b0);
    op1(3'd5, '0, '0, '0, '0, 1'b1);
    // Rotates
    load(8'h80);
    op1(3'd6, '0, '0, '0, '0, 1'b1);
    load(8'hFF);
    op1(3'd7, '0, '0, '0, '0, 1'b0);
    // Enable and clear priority
    load(8'h3C);
    drive(1'b0, 1'b1, 3'd1, 8'h00, '0, '0, '0, 1'b0);
    drive(1'b1, 1'b1, 3'd3, '0, '0, '0, 8'hFF, 1'b0);
    // TOGGLE then HOLD
    load(8'h55);
    op1(3'd3, '0, '0, '0, 8'hFF, 1'b0);
    op1(3'd0, '0, '0, '0, '0, 1'b0);

    mid_reset();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
            3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
            W'($urandom), 1'($urandom_range(0, 1)));
      if (n == 200) mid_reset();
    end

    go_idle();
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", (W+1)'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
